// File: rtl/pdm_spkr_stage_pkg.sv
// Shared definitions for the speaker PDM output stage: sample/gain widths,
// the offset-binary midpoint code, and the gain-scaling helper.
package pdm_spkr_stage_pkg;

    localparam int PDM_W  = 16;
    localparam int GAIN_W = 9;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;
    localparam logic [PDM_W-1:0]  MID_CODE   = 16'h8000;

    typedef logic signed [PDM_W-1:0] sample_t;
    typedef logic [GAIN_W-1:0]       gain_t;

    typedef struct packed {
        sample_t lft;
        sample_t rght;
    } stereo_t;

    // Scale a signed sample by gain/256 (arithmetic shift keeps the sign) and
    // flip the MSB so signed zero lands on the 50% duty code.
    function automatic logic [PDM_W-1:0] scale_to_offset(sample_t smp, gain_t g);
        logic signed [25:0] prod;
        prod = smp * $signed({1'b0, g});
        return prod[23:8] ^ MID_CODE;
    endfunction

endpackage

// File: rtl/pdm_spkr_stage_sd1.sv
// Single-channel first-order sigma-delta modulator. The active sample is
// refreshed on each tick and the accumulator carry becomes the PDM bit.
module pdm_sd1
    import pdm_spkr_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [PDM_W-1:0] din,
    output logic             pdm
);

    logic [PDM_W-1:0] active;
    logic [PDM_W-1:0] acc;
    logic [PDM_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, active};

    // On each tick: integrate the current active code, emit the carry, then load the newest sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            acc    <= '0;
            pdm    <= 1'b0;
        end else if (tick) begin
            acc    <= sum[PDM_W-1:0];
            pdm    <= sum[PDM_W];
            active <= din;
        end
    end

endmodule

// File: rtl/pdm_spkr_stage.sv
// Final audio stage: capture equalized stereo samples, apply a shared gain,
// convert to offset binary and drive one sigma-delta PDM stream per speaker.
// Build option: define PDM_SOFT_RAMP_EN for a stepped mute/unmute gain ramp;
// without it the gain switches straight between 0 and unity on each sample.
module pdm_spkr_stage
    import pdm_spkr_stage_pkg::*;
#(
    parameter int CLK_DIV   = 1,
    parameter int RAMP_STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld,
    input  logic signed [PDM_W-1:0] lft_chnnl,
    input  logic signed [PDM_W-1:0] rght_chnnl,
    input  logic                    mute,
    output logic                    lft_PDM,
    output logic                    rght_PDM,
    output logic                    muted
);

    if (CLK_DIV < 1 || CLK_DIV > 16 || RAMP_STEP < 1 || RAMP_STEP > 256) begin : g_param_check
        $error("pdm_spkr_stage: CLK_DIV or RAMP_STEP out of range");
    end

    localparam logic [3:0] TICK_LAST = 4'(CLK_DIV - 1);

    stereo_t          cap;
    logic             cap_vld;
    gain_t            gain;
    logic [PDM_W-1:0] din_lft;
    logic [PDM_W-1:0] din_rght;
    logic [3:0]       tick_cnt;
    logic             tick;

    // Latch both channels on the input strobe and remember a fresh capture is waiting to be scaled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap     <= '0;
            cap_vld <= 1'b0;
        end else begin
            cap_vld <= vld;
            if (vld) begin
                cap.lft  <= lft_chnnl;
                cap.rght <= rght_chnnl;
            end
        end
    end

`ifdef PDM_SOFT_RAMP_EN
    localparam logic [GAIN_W:0] STEP = (GAIN_W + 1)'(RAMP_STEP);

    logic [GAIN_W:0] gain_up;
    gain_t           gain_dn;
    gain_t           gain_next;

    // Saturating ramp: step toward zero while muted, toward unity otherwise.
    always_comb begin
        gain_up   = {1'b0, gain} + STEP;
        gain_dn   = gain - STEP[GAIN_W-1:0];
        gain_next = gain;
        if (mute) begin
            gain_next = ({1'b0, gain} <= STEP) ? '0 : gain_dn;
        end else begin
            gain_next = (gain_up >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_up[GAIN_W-1:0];
        end
    end

    // The gain moves only with accepted samples so the ramp rate tracks the audio rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            gain <= '0;
        end else if (vld) begin
            gain <= gain_next;
        end
    end
`else
    logic gain_sel;

    // Hard switch between silence and unity, taken on the next accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            gain_sel <= 1'b0;
        end else if (vld) begin
            gain_sel <= ~mute;
        end
    end

    assign gain = gain_sel ? GAIN_UNITY : '0;
`endif

    assign muted = (gain == '0);

    // Scale the captured pair one cycle after capture; idle until the first sample so reset output stays at code zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_lft  <= '0;
            din_rght <= '0;
        end else if (cap_vld) begin
            din_lft  <= scale_to_offset(cap.lft, gain);
            din_rght <= scale_to_offset(cap.rght, gain);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running divider that paces both modulators together.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    pdm_sd1 u_sd_lft (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .din  (din_lft),
        .pdm  (lft_PDM)
    );

    pdm_sd1 u_sd_rght (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .din  (din_rght),
        .pdm  (rght_PDM)
    );

endmodule

// File: tb/tb_pdm_spkr_stage.sv
// Self-checking bench for pdm_spkr_stage: two instances (CLK_DIV=1 and 8)
// share the stimulus and are compared every cycle against a behavioural model.
module tb_pdm_spkr_stage;

    localparam int STEP_P = 4;

    logic        clk;
    logic        rst;
    logic        vld;
    logic        mute;
    logic [15:0] lft;
    logic [15:0] rght;

    logic lft1, rght1, muted1;
    logic lft8, rght8, muted8;

    int checks = 0;
    int errors = 0;

    pdm_spkr_stage #(.CLK_DIV(1), .RAMP_STEP(STEP_P)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .vld        (vld),
        .lft_chnnl  (lft),
        .rght_chnnl (rght),
        .mute       (mute),
        .lft_PDM    (lft1),
        .rght_PDM   (rght1),
        .muted      (muted1)
    );

    pdm_spkr_stage #(.CLK_DIV(8), .RAMP_STEP(STEP_P)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .vld        (vld),
        .lft_chnnl  (lft),
        .rght_chnnl (rght),
        .mute       (mute),
        .lft_PDM    (lft8),
        .rght_PDM   (rght8),
        .muted      (muted8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        int gain;
        int stage_l;
        int stage_r;
        bit stage_vld;
        int din_l;
        int din_r;
        int act_l;
        int act_r;
        int acc_l;
        int acc_r;
        int cnt;
        bit pdm_l;
        bit pdm_r;
        bit tick;
    } model_t;

    model_t m1 = '0;
    model_t m8 = '0;

    // Signed product divided by 256 rounding toward minus infinity.
    function automatic int scaleFloor(logic [15:0] smp, int g);
        int p;
        p = int'($signed(smp)) * g;
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    function automatic int nextGain(int g, logic mu);
`ifdef PDM_SOFT_RAMP_EN
        if (mu) return (g > STEP_P) ? g - STEP_P : 0;
        return (g + STEP_P > 256) ? 256 : g + STEP_P;
`else
        return mu ? 0 : 256;
`endif
    endfunction

    // One clock of the stage: density modulator on ticks, two-cycle sample path, gain on samples.
    function automatic model_t step(model_t s, int div, logic r, logic v, logic mu,
                                    logic [15:0] l, logic [15:0] rr);
        model_t n;
        int sum;
        if (r) return '0;
        n = s;
        n.tick = (s.cnt == div - 1);
        if (n.tick) begin
            sum     = s.acc_l + s.act_l;
            n.pdm_l = (sum >= 65536);
            n.acc_l = sum % 65536;
            sum     = s.acc_r + s.act_r;
            n.pdm_r = (sum >= 65536);
            n.acc_r = sum % 65536;
            n.act_l = s.din_l;
            n.act_r = s.din_r;
            n.cnt   = 0;
        end else begin
            n.cnt = s.cnt + 1;
        end
        if (s.stage_vld) begin
            n.din_l = s.stage_l;
            n.din_r = s.stage_r;
        end
        n.stage_vld = v;
        if (v) begin
            n.gain    = nextGain(s.gain, mu);
            n.stage_l = scaleFloor(l, n.gain) + 32768;
            n.stage_r = scaleFloor(rr, n.gain) + 32768;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 <= step(m1, 1, rst, vld, mute, lft, rght);
        m8 <= step(m8, 8, rst, vld, mute, lft, rght);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    bit counting = 1'b0;
    int ones_l = 0;
    int ones_r = 0;
    bit prev_l8 = 1'b0;
    bit prev_r8 = 1'b0;

    // Per-cycle comparison of both instances against the model.
    task automatic compareCycle();
        checkOutput("lft_PDM_div1", lft1, m1.pdm_l);
        checkOutput("rght_PDM_div1", rght1, m1.pdm_r);
        checkOutput("muted_div1", muted1, (m1.gain == 0));
        checkOutput("lft_PDM_div8", lft8, m8.pdm_l);
        checkOutput("rght_PDM_div8", rght8, m8.pdm_r);
        checkOutput("muted_div8", muted8, (m8.gain == 0));
        checkOutput("lft8_toggle_off_tick", (lft8 ^ prev_l8) & ~m8.tick, 0);
        checkOutput("rght8_toggle_off_tick", (rght8 ^ prev_r8) & ~m8.tick, 0);
        prev_l8 = lft8;
        prev_r8 = rght8;
        if (counting) begin
            ones_l += int'(lft1);
            ones_r += int'(rght1);
        end
    endtask

    // Drive inputs for the next rising edge, then compare at the following falling edge.
    task automatic applyStimulus(input logic v, input logic mu, input logic [15:0] l, input logic [15:0] r);
        vld  = v;
        mute = mu;
        lft  = l;
        rght = r;
        @(negedge clk);
        compareCycle();
    endtask

    task automatic countOnes(input int n, input logic mu, input logic [15:0] l, input logic [15:0] r);
        ones_l   = 0;
        ones_r   = 0;
        counting = 1'b1;
        repeat (n) applyStimulus(1'b0, mu, l, r);
        counting = 1'b0;
    endtask

    initial begin
        int guard;
        int prev_stage;
        rst  = 1'b1;
        vld  = 1'b0;
        mute = 1'b0;
        lft  = '0;
        rght = '0;

        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("reset_muted", muted1, 1);
        checkOutput("reset_lft_PDM", lft1, 0);
        checkOutput("reset_rght_PDM", rght1, 0);
        repeat (10) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("idle_lft_PDM_zero", lft1, 0);
        checkOutput("idle_rght8_PDM_zero", rght8, 0);
        checkOutput("idle_still_muted", muted8, 1);

        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
            if (i == 1) checkOutput("unmute_first_vld", muted1, 0);
            applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        end
`ifdef PDM_SOFT_RAMP_EN
        checkOutput("model_gain_after_32", m1.gain, 128);
`else
        checkOutput("model_gain_after_32", m1.gain, 256);
`endif

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("midreset_muted", muted1, 1);
        checkOutput("midreset_muted8", muted8, 1);
        checkOutput("midreset_lft", lft1, 0);
        checkOutput("midreset_rght", rght1, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("post_reset_lft", lft1, 0);

        for (int i = 1; i <= 65; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
`ifdef PDM_SOFT_RAMP_EN
            if (i == 63) checkOutput("ramp_gain_63", m1.gain, 252);
`else
            if (i == 63) checkOutput("ramp_gain_63", m1.gain, 256);
`endif
            if (i == 64) checkOutput("ramp_gain_64", m1.gain, 256);
            if (i == 65) checkOutput("ramp_gain_65", m1.gain, 256);
            applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        end

        applyStimulus(1'b1, 1'b0, 16'h4000, 16'hC000);
        repeat (8) applyStimulus(1'b0, 1'b0, 16'h4000, 16'hC000);
        checkOutput("model_active_lft_C000", m1.act_l, 32'h0000C000);
        checkOutput("model_active_rght_4000", m1.act_r, 32'h00004000);
        countOnes(4096, 1'b0, 16'h4000, 16'hC000);
        checkRange("duty_lft_3_4", ones_l, 3071, 3073);
        checkRange("duty_rght_1_4", ones_r, 1023, 1025);

        guard = 0;
        while (!m8.tick && guard < 16) begin
            applyStimulus(1'b0, 1'b0, 16'h4000, 16'hC000);
            guard++;
        end
        checkOutput("tick_align_found", m8.tick, 1);
        applyStimulus(1'b1, 1'b0, 16'h1000, 16'h1000);
        applyStimulus(1'b0, 1'b0, 16'h1000, 16'h1000);
        applyStimulus(1'b1, 1'b0, 16'h2000, 16'h2000);
        applyStimulus(1'b0, 1'b0, 16'h2000, 16'h2000);
        applyStimulus(1'b1, 1'b0, 16'h3000, 16'h3000);
        applyStimulus(1'b0, 1'b0, 16'h3000, 16'h3000);
        applyStimulus(1'b0, 1'b0, 16'h3000, 16'h3000);
        checkOutput("div8_active_held", m8.act_l, 32'h0000C000);
        applyStimulus(1'b0, 1'b0, 16'h3000, 16'h3000);
        checkOutput("div8_tick_edge", m8.tick, 1);
        checkOutput("div8_loads_last", m8.act_l, 32'h0000B000);
        checkOutput("div8_loads_last_r", m8.act_r, 32'h0000B000);
        repeat (64) applyStimulus(1'b0, 1'b0, 16'h3000, 16'h3000);

        prev_stage = 32'h7FFFFFFF;
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
`ifdef PDM_SOFT_RAMP_EN
            checkOutput("ramp_dn_decreasing", (m1.stage_l < prev_stage), 1);
            if (i == 63) checkOutput("ramp_dn_not_yet_muted", muted1, 0);
`else
            checkOutput("ramp_dn_decreasing", (m1.stage_l <= prev_stage), 1);
`endif
            if (i == 64) begin
                checkOutput("ramp_dn_muted", muted1, 1);
                checkOutput("ramp_dn_mid_code", m1.stage_l, 32'h00008000);
            end
            prev_stage = m1.stage_l;
            applyStimulus(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
        end
        repeat (8) applyStimulus(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
        countOnes(4096, 1'b1, 16'h7FFF, 16'h7FFF);
        checkRange("muted_duty_lft_half", ones_l, 2047, 2049);
        checkRange("muted_duty_rght_half", ones_r, 2047, 2049);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
